// File: rtl/rom_pkg.sv
// Shared constants, state encoding and length clamp for the ROM image writer.
package rom_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // A burst can never write more words than the image holds.
    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
        logic [ADDR_W:0] depth_c;
        depth_c = (ADDR_W+1)'(DEPTH);
        return (l > depth_c) ? depth_c : l;
    endfunction

endpackage

// File: rtl/rom_image_writer_if.sv
// Valid/ready byte stream into the image writer.
interface rom_image_writer_if;
    import rom_pkg::*;

    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);

endinterface

// File: rtl/img_ram_1w1r.sv
// One-write one-read image RAM; the registered read returns the old word on a same-address write.
module img_ram_1w1r
    import rom_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // Contents survive reset so a partial load stays readable.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_reg[raddr];
        end
    end

endmodule

// File: rtl/rom_image_writer.sv
// Loads a burst of stream words into the image at an auto-incrementing, wrapping address.
module rom_image_writer
    import rom_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     len,
    rom_image_writer_if.slave   wr_if,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     wr_count,
    input  logic                en,
    input  logic [ADDR_W-1:0]   addres,
    output logic [DATA_W-1:0]   data_out
);

    state_t            state_reg;
    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W:0]   remaining_reg;
    logic [ADDR_W:0]   wr_count_reg;
    logic [ADDR_W:0]   len_clamped;
    logic              xfer;
    logic              ram_we;

    assign len_clamped    = clamp_len(len);
    assign wr_if.wr_ready = (state_reg == ST_LOAD);
    assign busy           = (state_reg == ST_LOAD);
    assign done           = (state_reg == ST_DONE);
    assign wr_count       = wr_count_reg;
    assign xfer           = wr_if.wr_valid && (state_reg == ST_LOAD);
    // A word offered in the reset cycle must not land in the image.
    assign ram_we         = xfer && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wptr_reg      <= '0;
            remaining_reg <= '0;
            wr_count_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        wptr_reg      <= base_addr;
                        remaining_reg <= len_clamped;
                        wr_count_reg  <= '0;
                        state_reg     <= (len_clamped == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        wptr_reg      <= wptr_reg + 1'b1;
                        wr_count_reg  <= wr_count_reg + 1'b1;
                        remaining_reg <= remaining_reg - 1'b1;
                        if (remaining_reg == (ADDR_W+1)'(1)) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    img_ram_1w1r u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (wptr_reg),
        .wdata (wr_if.wr_data),
        .re    (en),
        .raddr (addres),
        .rdata (data_out)
    );

endmodule

// File: tb/tb_rom_image_writer.sv
// Scenario bench for rom_image_writer with a reference image and a read scoreboard.
module tb_rom_image_writer;
    import rom_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   wr_count;
    logic              en;
    logic [ADDR_W-1:0] addres;
    logic [DATA_W-1:0] data_out;

    rom_image_writer_if wr_if ();

    rom_image_writer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .wr_if     (wr_if),
        .busy      (busy),
        .done      (done),
        .wr_count  (wr_count),
        .en        (en),
        .addres    (addres),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    // Pipelined reads: expectation queued at issue, compared one edge later.
    task automatic read_range(input logic [ADDR_W-1:0] a0, input int n);
        logic [DATA_W-1:0] e;
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < n; i++) begin
            a = a0 + ADDR_W'(i);
            en = 1'b1;
            addres = a;
            exp_q.push_back(model_mem[a]);
            tick();
            e = exp_q.pop_front();
            tests++;
            if (data_out !== e) begin
                fails++;
                $display("FAIL read[%0d]: got %0h expected %0h", a, data_out, e);
            end else begin
                $display("[TB] read[%0d] = %0h", a, data_out);
            end
        end
        en = 1'b0;
    endtask

    task automatic start_burst(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l);
        start = 1'b1;
        base_addr = b;
        len = l;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0; base_addr = '0; len = '0;
        wr_if.wr_valid = 1'b0; wr_if.wr_data = '0;
        en = 1'b0; addres = '0;
        tick(); tick();
        chk("reset_wr_ready", int'(wr_if.wr_ready), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_wr_count", int'(wr_count), 0);
        chk("reset_data_out", int'(data_out), 0);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_load();
        start_burst(3'd0, 4'd8);
        for (int i = 0; i < 8; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data = 8'h10 + 8'(i);
            tests++;
            if (wr_if.wr_ready !== 1'b1 || done !== 1'b0) begin
                fails++;
                $display("FAIL basic_ready[%0d]: ready=%0b done=%0b expected ready=1 done=0", i, wr_if.wr_ready, done);
            end else begin
                $display("[TB] basic write %0d", i);
            end
            model_mem[i] = 8'h10 + 8'(i);
            tick();
        end
        wr_if.wr_valid = 1'b0;
        chk("basic_done_cycle9", int'(done), 1);
        chk("basic_ready_in_done", int'(wr_if.wr_ready), 0);
        chk("basic_wr_count", int'(wr_count), 8);
        tick();
        chk("basic_done_one_pulse", int'(done), 0);
        chk("basic_wr_count_hold", int'(wr_count), 8);
        read_range(3'd0, 8);
        // en low must hold the last read word
        tick();
        chk("read_hold_en0", int'(data_out), int'(model_mem[7]));
    endtask

    task automatic test_wrap_stall();
        logic [DATA_W-1:0] nxt;
        int busy_cycles;
        int k;
        bit pattern [6];
        pattern = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        busy_cycles = 0;
        k = 0;
        nxt = 8'hA0;
        start_burst(3'd6, 4'd4);
        for (int c = 0; c < 6; c++) begin
            if (busy) busy_cycles++;
            wr_if.wr_valid = pattern[c];
            wr_if.wr_data = nxt;
            if (pattern[c] && wr_if.wr_ready) begin
                model_mem[3'd6 + 3'(k)] = nxt;
                k++;
                nxt++;
            end
            tick();
        end
        wr_if.wr_valid = 1'b0;
        chk("wrap_busy_cycles", busy_cycles, 5);
        chk("wrap_wr_count", int'(wr_count), 4);
        read_range(3'd6, 5);
    endtask

    task automatic test_zero_clamp();
        int accepted;
        int pulses;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data = 8'hEE;
        start_burst(3'd0, 4'd0);
        chk("zero_done", int'(done), 1);
        chk("zero_wr_count", int'(wr_count), 0);
        chk("zero_busy", int'(busy), 0);
        tick();
        chk("zero_done_clear", int'(done), 0);
        wr_if.wr_valid = 1'b0;
        read_range(3'd0, 2);

        accepted = 0;
        pulses = 0;
        start_burst(3'd2, 4'd12);
        for (int c = 0; c < 12; c++) begin
            if (done) pulses++;
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data = 8'h30 + 8'(c);
            if (wr_if.wr_ready) begin
                model_mem[3'd2 + 3'(accepted)] = 8'h30 + 8'(c);
                accepted++;
            end
            tick();
        end
        wr_if.wr_valid = 1'b0;
        chk("clamp_accepted", accepted, 8);
        chk("clamp_done_pulses", pulses, 1);
        chk("clamp_wr_count", int'(wr_count), 8);
        read_range(3'd0, 8);
    endtask

    task automatic test_collision_ignored_start();
        logic [DATA_W-1:0] old;
        start_burst(3'd3, 4'd1);
        old = model_mem[3];
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data = 8'h55;
        en = 1'b1;
        addres = 3'd3;
        tick();
        wr_if.wr_valid = 1'b0;
        en = 1'b0;
        chk("collision_old_word", int'(data_out), int'(old));
        chk("collision_done", int'(done), 1);
        model_mem[3] = 8'h55;
        read_range(3'd3, 1);

        start_burst(3'd0, 4'd2);
        // Re-start attempt inside LOAD must not disturb pointer or length
        start = 1'b1; base_addr = 3'd5; len = 4'd8;
        wr_if.wr_valid = 1'b1; wr_if.wr_data = 8'h61;
        tick();
        model_mem[0] = 8'h61;
        wr_if.wr_data = 8'h62;
        tick();
        model_mem[1] = 8'h62;
        wr_if.wr_valid = 1'b0;
        chk("ignored_start_done", int'(done), 1);
        chk("ignored_start_wr_count", int'(wr_count), 2);
        tick();
        start = 1'b0;
        tick();
        chk("ignored_start_idle", int'(busy), 0);
        read_range(3'd0, 8);
    endtask

    task automatic test_reset_mid_burst();
        int pulses;
        start_burst(3'd4, 4'd6);
        for (int i = 0; i < 3; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data = 8'h70 + 8'(i);
            model_mem[3'd4 + 3'(i)] = 8'h70 + 8'(i);
            en = 1'b1;
            addres = 3'd0;
            tick();
        end
        en = 1'b0;
        wr_if.wr_data = 8'h99;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_if.wr_valid = 1'b0;
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(wr_if.wr_ready), 0);
        chk("rst_mid_wr_count", int'(wr_count), 0);
        chk("rst_mid_data_out", int'(data_out), 0);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            if (done) pulses++;
            tick();
        end
        chk("rst_mid_no_done", pulses, 0);
        read_range(3'd4, 4);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_wrap_stall();
        test_zero_clamp();
        test_collision_ignored_start();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
